// File: rtl/lfsr_gen.sv
// Free-running maximal-length Fibonacci LFSR; data_o is the state register itself.
// Zero state (upset/forced) self-recovers by reloading the effective seed on the next edge.
module lfsr_gen #(
  parameter int unsigned WIDTH = 4,
  parameter logic [31:0] SEED  = 32'd1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [WIDTH-1:0] data_o
);

  // XOR tap masks: bit (n-1) set for tap n
  function automatic logic [31:0] tap_mask32(input int unsigned w);
    case (w)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH=%0d outside legal range 2..32", WIDTH);
    end
  endgenerate

  localparam logic [WIDTH-1:0] TAPS     = WIDTH'(tap_mask32(WIDTH));
  localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED_W == '0) ? WIDTH'(1) : SEED_W;

  logic [WIDTH-1:0] r_state;
  logic             w_fb;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_fb   = ^(r_state & TAPS);
    w_next = {r_state[WIDTH-2:0], w_fb};
  end

  // Reset wins over shift; all-zero lockup reloads the seed instead of shifting
  always_ff @(posedge clk_i) begin
    if (rst_i || (r_state == '0)) begin
      r_state <= SEED_EFF;
    end else begin
      r_state <= w_next;
    end
  end

  assign data_o = r_state;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: vector table, random-reset model compare,
// period/coverage sweeps for several widths, and zero-lockup recovery.
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  d_w4s1, d_w4s0, d_w4s5;
  logic [2:0]  d_w3;
  logic [7:0]  d_w8;
  logic [15:0] d_w16;

  lfsr_gen #(.WIDTH(4),  .SEED(32'd1)) u_w4s1 (.clk_i(clk), .rst_i(rst), .data_o(d_w4s1));
  lfsr_gen #(.WIDTH(4),  .SEED(32'd0)) u_w4s0 (.clk_i(clk), .rst_i(rst), .data_o(d_w4s0));
  lfsr_gen #(.WIDTH(4),  .SEED(32'd5)) u_w4s5 (.clk_i(clk), .rst_i(rst), .data_o(d_w4s5));
  lfsr_gen #(.WIDTH(3),  .SEED(32'd1)) u_w3   (.clk_i(clk), .rst_i(rst), .data_o(d_w3));
  lfsr_gen #(.WIDTH(8),  .SEED(32'd1)) u_w8   (.clk_i(clk), .rst_i(rst), .data_o(d_w8));
  lfsr_gen #(.WIDTH(16), .SEED(32'd1)) u_w16  (.clk_i(clk), .rst_i(rst), .data_o(d_w16));

  localparam int NDUT = 6;
  int          dut_w [NDUT] = '{4, 4, 4, 3, 8, 16};
  int unsigned dut_s [NDUT] = '{1, 0, 5, 1, 1, 1};
  logic [31:0] d [NDUT];
  assign d[0] = 32'(d_w4s1);
  assign d[1] = 32'(d_w4s0);
  assign d[2] = 32'(d_w4s5);
  assign d[3] = 32'(d_w3);
  assign d[4] = 32'(d_w8);
  assign d[5] = 32'(d_w16);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit r);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    #1;
  endtask

  // Tap list straight from the width table (1-based tap numbers)
  function automatic void taps_of(input int w, output int t[4]);
    t = '{0, 0, 0, 0};
    case (w)
      3:  t = '{3, 2, 0, 0};
      4:  t = '{4, 3, 0, 0};
      8:  t = '{8, 6, 5, 4};
      16: t = '{16, 15, 13, 4};
      default: ;
    endcase
  endfunction

  // Reference next value: arithmetic shift-and-parity over the tap list
  function automatic int unsigned mnext(input int w, input int unsigned seed,
                                        input int unsigned s, input bit r);
    int unsigned modv, eff, fb;
    int t[4];
    modv = 1 << w;
    eff  = seed % modv;
    if (eff == 0) eff = 1;
    if (r || s == 0) return eff;
    taps_of(w, t);
    fb = 0;
    for (int k = 0; k < 4; k++)
      if (t[k] != 0) fb = fb ^ ((s >> (t[k] - 1)) & 1);
    return (s * 2 + fb) % modv;
  endfunction

  typedef struct {
    bit         rst;
    logic [3:0] exp;
  } vec_t;

  vec_t        tbl[$];
  int unsigned m [NDUT];
  bit          seen [3][65536];
  int          bad [3];
  int          cnt [3];

  initial begin
    int seq [15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
    int head [7] = '{2, 4, 9, 3, 6, 13, 10};
    int tail [3] = '{2, 4, 9};

    // Reset then full period, mid-run reset, then reset held for 5 edges
    tbl.push_back('{1'b1, 4'd1});
    foreach (seq[i]) tbl.push_back('{1'b0, 4'(seq[i])});
    tbl.push_back('{1'b1, 4'd1});
    foreach (head[i]) tbl.push_back('{1'b0, 4'(head[i])});
    tbl.push_back('{1'b1, 4'd1});
    foreach (tail[i]) tbl.push_back('{1'b0, 4'(tail[i])});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 4'd1});
    tbl.push_back('{1'b0, 4'd2});
    tbl.push_back('{1'b0, 4'd4});

    foreach (tbl[i]) begin
      step(tbl[i].rst);
      chk($sformatf("vec%0d w4s1", i), 32'(d_w4s1), 32'(tbl[i].exp));
      chk($sformatf("vec%0d w4s0", i), 32'(d_w4s0), 32'(tbl[i].exp));
      if (tbl[i].rst) chk($sformatf("vec%0d w4s5 seed", i), 32'(d_w4s5), 32'd5);
    end

    // Random reset pulses, every instance against the model
    for (int c = 0; c < 400; c++) begin
      bit r;
      r = (c == 0) || ($urandom_range(0, 9) == 0);
      step(r);
      for (int i = 0; i < NDUT; i++) begin
        m[i] = mnext(dut_w[i], dut_s[i], m[i], r);
        chk($sformatf("rand c%0d dut%0d", c, i), d[i], 32'(m[i]));
      end
    end

    // Period and coverage for widths 3, 8, 16 (sample k=0 is post-reset)
    for (int i = 0; i < 3; i++) begin
      bad[i] = 0;
      cnt[i] = 0;
    end
    step(1'b1);
    for (int k = 0; k < 65536; k++) begin
      if (k > 0) step(1'b0);
      for (int i = 0; i < 3; i++) begin
        int w;
        int n;
        logic [31:0] v;
        w = dut_w[i + 3];
        n = (1 << w) - 1;
        v = d[i + 3];
        if (k < n) begin
          if ($isunknown(v) || v == 0 || v > 32'(n) || seen[i][v[15:0]]) bad[i]++;
          else begin
            seen[i][v[15:0]] = 1'b1;
            cnt[i]++;
          end
        end else if (k == n) begin
          chk($sformatf("period w%0d repeat", w), v, 32'd1);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cover w%0d zero/dup", dut_w[i + 3]), 32'(bad[i]), 32'd0);
      chk($sformatf("cover w%0d distinct", dut_w[i + 3]), 32'(cnt[i]), 32'((1 << dut_w[i + 3]) - 1));
    end

    // Zero-state lockup on the SEED=5 instance
    step(1'b1);
    chk("lock pre seed", 32'(d_w4s5), 32'd5);
    @(negedge clk);
    rst = 1'b0;
    force u_w4s5.r_state = 4'd0;
    @(posedge clk);
    @(negedge clk);
    release u_w4s5.r_state;
    #1;
    if (d_w4s5 == 4'd0) begin
      @(posedge clk);
      #1;
    end
    chk("lock reload", 32'(d_w4s5), 32'd5);
    @(posedge clk);
    #1;
    chk("lock next", 32'(d_w4s5), 32'd11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Free-running maximal-length Fibonacci LFSR that emits a pseudo-random value every clock.
- Used by memory/bus slave models (e.g. AXI-lite DRAM model) as a cheap source of random latency values (4-bit by default).
- No inputs other than clock and reset; the output is consumed asynchronously by the instantiating logic.

Parameters:
- WIDTH, 4, state and output width; legal range 2..32, anything else must raise an elaboration error.
- SEED, 1, reset value of the state (low WIDTH bits used); if it resolves to zero, the effective seed is 1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- data_o  output  WIDTH  current LFSR state, driven directly from the state register (no combinational path from inputs).

Behaviour:
- Reset:
  - At any rising edge with rst_i=1, state <= effective SEED.
  - data_o equals effective SEED from the cycle after that edge.
  - Reset has priority over the shift.
  - Reset mid-sequence restarts the sequence from SEED on the next edge.
- Shift (rst_i=0, each rising edge):
  - state <= {state[WIDTH-2:0], fb}, i.e. shift toward MSB with feedback into bit 0.
  - fb = XOR of tapped bits.
  - Tap n (1-based) refers to state[n-1].
- Taps per WIDTH (maximal-length, XOR form):
  - 2:2,1  3:3,2  4:4,3  5:5,3  6:6,5  7:7,6  8:8,6,5,4  9:9,5  10:10,7  11:11,9
  - 12:12,6,4,1  13:13,4,3,1  14:14,5,3,1  15:15,14  16:16,15,13,4  17:17,14  18:18,11
  - 19:19,6,2,1  20:20,17  21:21,19  22:22,21  23:23,18  24:24,23,22,17  25:25,22
  - 26:26,6,2,1  27:27,5,2,1  28:28,25  29:29,27  30:30,6,4,1  31:31,28  32:32,22,2,1
  - Tap selection is done by a parameter-driven lookup (function or generate), not by per-width copies of the state machine.
- Sequence properties:
  - Period is 2^WIDTH-1.
  - All nonzero values appear exactly once per period.
  - Zero never appears in normal operation.
- Lockup recovery:
  - If state is ever all-zero (e.g. upset or forced value), the next edge loads the effective SEED instead of shifting.
  - The zero state therefore lasts at most one cycle.
- WIDTH=4, SEED=1 reference sequence starting after reset:
  - 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8, then 1 again.
- Simulation hygiene: data_o is never X after the first reset edge.

Test Plan:
- WIDTH=4, SEED=1: assert rst_i one edge, release -> data_o = 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8,1 on consecutive cycles.
- Reset mid-run: release reset, run 7 cycles (data_o=10), assert rst_i one edge -> data_o=1 next cycle, then 2,4,9 after release.
- Period/coverage, WIDTH in {3,4,8,16}: run 2^WIDTH cycles -> first repeat of the post-reset value at exactly 2^WIDTH-1 cycles, every nonzero value seen once, 0 never seen.
- SEED=0 with WIDTH=4: after reset data_o=1, and the sequence is identical to the SEED=1 case.
- Lockup: force state to 0 for one edge, release (WIDTH=4, SEED=5) -> next cycle data_o=5, then 11.
- rst_i held high for 5 edges -> data_o stays at SEED throughout; first shift occurs on the first edge with rst_i=0.
